ram_bus_sequencer: RTL and testbench

- Bus master that drives the 8-phase instruction-cycle bus (sync, cmd_n, 4-bit data) for the 4002-style data RAM chips.
- Converts simple write requests (chip, register, character, nibble) into properly phased SRC and WRM instruction cycles.
- Emits NOP cycles when idle.
- Sits between the host-side test/CPU logic and the RAM chips. It owns phase alignment with the chips' free-running cycle counters.

---
 rtl/ram_bus_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ram_bus_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_sequencer.sv
// ram_bus_sequencer
// Bus master for 4002-style data RAM chips. Turns write requests
// (chip, register, character, nibble) into phased SRC + WRM instruction
// cycles on the 8-phase bus and emits NOP cycles when idle. The phase
// counter resets to 0 together with the RAM chips and never stalls, so
// every instruction cycle is exactly 8 clocks.
//
// Optional feature (macro SRC_CACHE_EN): remember the last SRC address and
// skip the SRC cycle when a request targets the same {chip, reg, char}.
//
// Ports:
//   clock, reset         system clock (one bus phase per clock), sync active-high reset
//   req_valid/req_ready  request handshake; accept only at phase 7 of IDLE/WRM
//   req_chip/reg/char    target address; req_data nibble to write
//   sync                 high in phase 7
//   cmd_n                active-low command strobe
//   bus_data, bus_oe     data bus value and drive enable
//   phase                current phase 0..7
//   busy                 an SRC or WRM cycle is in progress
//
// All outputs are registers loaded from the next phase/state/fields, so no
// output depends combinationally on req_*.

module ram_bus_sequencer #(
  parameter logic [7:0] NOP_OPCODE = 8'h00,
  parameter logic [7:0] SRC_OPCODE = 8'h21,
  parameter logic [7:0] WRM_OPCODE = 8'hE0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_chip,
  input  logic [1:0] req_reg,
  input  logic [3:0] req_char,
  input  logic [3:0] req_data,
  output logic       sync,
  output logic       cmd_n,
  output logic [3:0] bus_data,
  output logic       bus_oe,
  output logic [2:0] phase,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SRC_CYC = 2'd1,
    WRM_CYC = 2'd2
  } state_t;

  state_t     state_r, state_nx_s;
  logic [2:0] phase_r, phase_nx_s;
  logic       chip_r, chip_nx_s;
  logic [1:0] reg_r, reg_nx_s;
  logic [3:0] char_r, char_nx_s;
  logic [3:0] data_r, data_nx_s;

  logic       accept_s;
  logic       need_src_s;
  logic [7:0] opcode_s;
  logic [3:0] drv_data_s;
  logic       drv_oe_s;
  logic       drv_cmd_n_s;

  logic       sync_r, cmd_n_r, bus_oe_r, req_ready_r, busy_r;
  logic [3:0] bus_data_r;

  // req_ready_r is already qualified by phase 7 and state, so this is the handshake.
  assign accept_s = req_valid && req_ready_r;

`ifdef SRC_CACHE_EN
  logic [6:0] last_src_r;
  logic       src_valid_r;

  // Cache the address of the most recent SRC; set at the end of each SRC cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_src_r  <= 7'd0;
      src_valid_r <= 1'b0;
    end else if ((phase_r == 3'd7) && (state_r == SRC_CYC)) begin
      last_src_r  <= {chip_r, reg_r, char_r};
      src_valid_r <= 1'b1;
    end else begin
      last_src_r  <= last_src_r;
      src_valid_r <= src_valid_r;
    end
  end

  assign need_src_s = !src_valid_r || ({req_chip, req_reg, req_char} != last_src_r);
`else
  assign need_src_s = 1'b1;
`endif

  // Next phase, next state and request latching; state only moves at the phase-7 edge.
  always_comb begin
    phase_nx_s = phase_r + 3'd1;
    state_nx_s = state_r;
    chip_nx_s  = chip_r;
    reg_nx_s   = reg_r;
    char_nx_s  = char_r;
    data_nx_s  = data_r;
    if (phase_r == 3'd7) begin
      if (accept_s) begin
        chip_nx_s  = req_chip;
        reg_nx_s   = req_reg;
        char_nx_s  = req_char;
        data_nx_s  = req_data;
        state_nx_s = need_src_s ? SRC_CYC : WRM_CYC;
      end else begin
        case (state_r)
          SRC_CYC: state_nx_s = WRM_CYC;
          WRM_CYC: state_nx_s = IDLE;
          IDLE:    state_nx_s = IDLE;
          default: state_nx_s = IDLE;
        endcase
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // Bus drive for the phase/state that will be current after this edge.
  always_comb begin
    case (state_nx_s)
      SRC_CYC: opcode_s = SRC_OPCODE;
      WRM_CYC: opcode_s = WRM_OPCODE;
      default: opcode_s = NOP_OPCODE;
    endcase
    drv_data_s  = 4'h0;
    drv_oe_s    = 1'b1;
    drv_cmd_n_s = 1'b1;
    case (phase_nx_s)
      3'd3: drv_data_s = opcode_s[7:4];
      3'd4: begin
        drv_data_s = opcode_s[3:0];
        if (state_nx_s == WRM_CYC) begin
          drv_cmd_n_s = 1'b0;
        end else begin
          drv_cmd_n_s = 1'b1;
        end
      end
      3'd5: drv_oe_s = 1'b0;
      3'd6: begin
        case (state_nx_s)
          SRC_CYC: begin
            drv_cmd_n_s = 1'b0;
            drv_data_s  = {1'b0, chip_nx_s, reg_nx_s};
          end
          WRM_CYC: drv_data_s = data_nx_s;
          default: drv_oe_s = 1'b0;
        endcase
      end
      3'd7: begin
        case (state_nx_s)
          SRC_CYC: drv_data_s = char_nx_s;
          default: drv_oe_s = 1'b0;
        endcase
      end
      default: drv_data_s = 4'h0;
    endcase
  end

  // State, phase, latched request fields and registered bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      phase_r     <= 3'd0;
      chip_r      <= 1'b0;
      reg_r       <= 2'd0;
      char_r      <= 4'd0;
      data_r      <= 4'd0;
      sync_r      <= 1'b0;
      cmd_n_r     <= 1'b1;
      bus_data_r  <= 4'h0;
      bus_oe_r    <= 1'b1;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      phase_r     <= phase_nx_s;
      chip_r      <= chip_nx_s;
      reg_r       <= reg_nx_s;
      char_r      <= char_nx_s;
      data_r      <= data_nx_s;
      sync_r      <= (phase_nx_s == 3'd7);
      cmd_n_r     <= drv_cmd_n_s;
      bus_data_r  <= drv_data_s;
      bus_oe_r    <= drv_oe_s;
      req_ready_r <= (phase_nx_s == 3'd7) &&
                     ((state_nx_s == IDLE) || (state_nx_s == WRM_CYC));
      busy_r      <= (state_nx_s != IDLE);
    end
  end

  assign sync      = sync_r;
  assign cmd_n     = cmd_n_r;
  assign bus_data  = bus_data_r;
  assign bus_oe    = bus_oe_r;
  assign req_ready = req_ready_r;
  assign phase     = phase_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_ram_bus_sequencer.sv
// Scoreboard bench for ram_bus_sequencer. Stimulus pushes the expected
// instruction cycles and RAM-latch clock numbers into queues at accept time;
// a monitor decodes the bus every clock, pops and compares at phase 6/7, and
// drives a small 4002-style RAM model.
module tb_ram_bus_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_chip;
  logic [1:0] req_reg;
  logic [3:0] req_char, req_data;
  logic       sync, cmd_n, bus_oe, busy;
  logic [3:0] bus_data;
  logic [2:0] phase;

  ram_bus_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_chip(req_chip), .req_reg(req_reg), .req_char(req_char), .req_data(req_data),
    .sync(sync), .cmd_n(cmd_n), .bus_data(bus_data), .bus_oe(bus_oe),
    .phase(phase), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] op;
    logic       oe6;
    logic [3:0] x2;
    logic       oe7;
    logic [3:0] x3;
    logic       cmd4;
    logic       cmd6;
  } cyc_t;

  cyc_t       exp_q[$];
  int         wr_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [2:0] tb_ph = 3'd0;
  logic [3:0] mem [0:127];
  int         sync_cnt, cmd_lo_cnt, nz_op_cnt;
  logic [7:0] cap_op;
  logic       cap_cmd4, cap_cmd6, cap_oe6, cap_oe7;
  logic [3:0] cap_x2, cap_x3;
  logic [6:0] ram_sel;
`ifdef SRC_CACHE_EN
  logic       m_valid = 1'b0;
  logic [6:0] m_last = 7'd0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference phase counter and clock-edge counter.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) tb_ph <= 3'd0;
    else       tb_ph <= tb_ph + 3'd1;
  end

  // Monitor: decode the bus on the falling edge, compare, update RAM model.
  always @(negedge clock) begin
    if (!reset) begin
      chk("phase", {29'd0, phase}, {29'd0, tb_ph});
      chk("sync", {31'd0, sync}, {31'd0, (tb_ph == 3'd7)});
      if (sync) sync_cnt++;
      if (!cmd_n) begin
        cmd_lo_cnt++;
        chk("cmd_n_phase", {31'd0, (tb_ph == 3'd4 || tb_ph == 3'd6)}, 32'd1);
      end
      case (tb_ph)
        3'd3: begin
          cap_op[7:4] = bus_data;
          if (bus_data != 4'h0) nz_op_cnt++;
          chk("opr_oe", {31'd0, bus_oe}, 32'd1);
        end
        3'd4: begin
          cap_op[3:0] = bus_data;
          cap_cmd4 = cmd_n;
          if (bus_data != 4'h0) nz_op_cnt++;
        end
        3'd5: chk("x1_float", {31'd0, bus_oe}, 32'd0);
        3'd6: begin
          cap_cmd6 = cmd_n;
          cap_x2 = bus_data;
          cap_oe6 = bus_oe;
          if (!cap_cmd4) begin
            // RAM latches at the edge that ends phase 6, i.e. edge cyc+1.
            if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else chk("wr_latency", cyc + 1, wr_q.pop_front());
          end
        end
        3'd7: begin
          cap_x3 = bus_data;
          cap_oe7 = bus_oe;
          if (cap_op != 8'h00) begin
            if (exp_q.size() == 0) begin
              chk("cyc_unexpected", {24'd0, cap_op}, 32'd0);
            end else begin
              cyc_t e;
              e = exp_q.pop_front();
              chk("cyc_op", {24'd0, cap_op}, {24'd0, e.op});
              chk("cyc_x2", {27'd0, cap_oe6, cap_x2}, {27'd0, e.oe6, e.x2});
              chk("cyc_x3", {27'd0, cap_oe7, cap_x3}, {27'd0, e.oe7, e.x3});
              chk("cyc_cmd", {30'd0, cap_cmd4, cap_cmd6}, {30'd0, e.cmd4, e.cmd6});
            end
          end
          if (!cap_cmd6 && cap_oe6) ram_sel = {cap_x2[2:0], cap_x3};
          if (!cap_cmd4) mem[ram_sel] = cap_x2;
        end
        default: chk("addr_drive", {27'd0, bus_oe, bus_data}, 32'h10);
      endcase
    end
  end

  task automatic do_write(input logic c, input logic [1:0] r, input logic [3:0] ch,
                          input logic [3:0] d, input bit from_p2, output int acc);
    bit got;
    bit need;
    got = 1'b0;
    acc = 0;
    if (from_p2) begin
      for (int i = 0; i < 16 && tb_ph != 3'd2; i++) @(negedge clock);
    end
    req_valid = 1'b1; req_chip = c; req_reg = r; req_char = ch; req_data = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (req_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      chk("ready_phase", {29'd0, tb_ph}, 32'd7);
      acc = cyc + 1;
      need = 1'b1;
`ifdef SRC_CACHE_EN
      need = !m_valid || ({c, r, ch} != m_last);
      m_valid = 1'b1;
      m_last = {c, r, ch};
`endif
      if (need) exp_q.push_back({8'h21, 1'b1, {1'b0, c, r}, 1'b1, ch, 1'b1, 1'b0});
      exp_q.push_back({8'hE0, 1'b1, d, 1'b0, 4'h0, 1'b0, 1'b1});
      wr_q.push_back(acc + (need ? 15 : 7));
      @(posedge clock);
      #1;
      // Scramble fields after accept; the driven cycle must not change.
      req_valid = 1'b0; req_chip = ~c; req_reg = ~r; req_char = ~ch; req_data = ~d;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (exp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clock);
    @(negedge clock);
    chk("drain", exp_q.size() + wr_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, a4, a0;
    for (int i = 0; i < 128; i++) mem[i] = 4'h0;
    reset = 1'b1; req_valid = 1'b0; req_chip = 1'b0; req_reg = 2'd0; req_char = 4'd0; req_data = 4'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_outputs", {25'd0, phase, sync, cmd_n, bus_oe, req_ready},
        {25'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk("rst_data_busy", {27'd0, bus_data, busy}, 32'd0);
    reset = 1'b0;

    // Idle: 32 clocks of NOPs.
    @(posedge clock); #1;
    sync_cnt = 0; cmd_lo_cnt = 0; nz_op_cnt = 0;
    repeat (32) @(negedge clock);
    #1;
    chk("idle_sync_cnt", sync_cnt, 32'd4);
    chk("idle_cmd_lo", cmd_lo_cnt, 32'd0);
    chk("idle_opcode", nz_op_cnt, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single write, request raised in phase 2.
    do_write(1'b0, 2'd2, 4'd5, 4'hA, 1'b1, a0);
    drain();
    chk("mem_37", {28'd0, mem[37]}, 32'hA);

    // Back-to-back writes: repeat address, new char, other chip.
    do_write(1'b0, 2'd1, 4'd7, 4'h9, 1'b0, a1);
    do_write(1'b0, 2'd1, 4'd7, 4'h3, 1'b0, a2);
    do_write(1'b0, 2'd1, 4'd8, 4'h6, 1'b0, a3);
    do_write(1'b1, 2'd3, 4'd15, 4'hC, 1'b0, a4);
    chk("gap_after_miss", a2 - a1, 32'd16);
`ifdef SRC_CACHE_EN
    chk("gap_after_repeat", a3 - a2, 32'd8);
`else
    chk("gap_after_repeat", a3 - a2, 32'd16);
`endif
    chk("gap_after_newchar", a4 - a3, 32'd16);
    drain();
    chk("mem_23", {28'd0, mem[23]}, 32'h3);
    chk("mem_24", {28'd0, mem[24]}, 32'h6);
    chk("mem_127", {28'd0, mem[127]}, 32'hC);

    // Reset in phase 5 of the WRM cycle: write must be dropped.
    do_write(1'b0, 2'd0, 4'd3, 4'h7, 1'b0, a0);
    repeat (13) @(posedge clock);
    @(negedge clock);
    chk("abort_point", {28'd0, busy, tb_ph}, {28'd0, 1'b1, 3'd5});
    reset = 1'b1;
    exp_q.delete();
    wr_q.delete();
`ifdef SRC_CACHE_EN
    m_valid = 1'b0;
`endif
    @(negedge clock);
    chk("abort_state", {27'd0, phase, cmd_n, busy}, {27'd0, 3'd0, 1'b1, 1'b0});
    reset = 1'b0;
    repeat (12) @(negedge clock);
    chk("abort_mem_3", {28'd0, mem[3]}, 32'h0);
    do_write(1'b0, 2'd0, 4'd3, 4'h7, 1'b0, a0);
    drain();
    chk("mem_3", {28'd0, mem[3]}, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
